// File: rtl/vend_ctrl.sv
// ----------------------------------------------------------------------------
// vend_ctrl
//   Coin-operated vending controller. It accepts coins into a credit register,
//   vends a product when enough credit is present or when a free-vend (PASS)
//   request arrives, returns change one CHG_UNIT at a time, and refunds all
//   credit on CANCEL or after TIMEOUT idle cycles while holding credit.
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset
//   COIN_VLD   in   coin inserted this cycle
//   COIN_VAL   in   [CW]  coin value in cents
//   SEL_VLD    in   product selection strobe
//   SEL        in   [SW]  product index
//   PASS       in   free vend of SEL
//   CANCEL     in   refund request
//   CREDIT     out  [CW]  current credit
//   VEND       out  one-cycle dispense pulse
//   VEND_ID    out  [SW]  product dispensed, valid with VEND
//   COIN_REJ   out  one-cycle coin-returned pulse
//   CHG_PULSE  out  one pulse per CHG_UNIT cents returned
//   BUSY       out  high while vending or returning change
// ----------------------------------------------------------------------------
module vend_ctrl #(
    parameter int                   CW         = 8,
    parameter int                   N_PROD     = 4,
    parameter logic [N_PROD*CW-1:0] PRICES     = {8'd75, 8'd50, 8'd50, 8'd25},
    parameter int                   MAX_CREDIT = 200,
    parameter int                   CHG_UNIT   = 5,
    parameter int                   TIMEOUT    = 1000,
    localparam int                  SW         = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          COIN_VLD,
    input  logic [CW-1:0] COIN_VAL,
    input  logic          SEL_VLD,
    input  logic [SW-1:0] SEL,
    input  logic          PASS,
    input  logic          CANCEL,
    output logic [CW-1:0] CREDIT,
    output logic          VEND,
    output logic [SW-1:0] VEND_ID,
    output logic          COIN_REJ,
    output logic          CHG_PULSE,
    output logic          BUSY
);

    typedef enum logic [1:0] {S_IDLE, S_HOLD, S_VEND, S_CHANGE} state_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t        state, state_nx;
    logic [CW-1:0] credit_nx;
    logic [SW-1:0] vend_id_nx;
    logic          vend_nx, coin_rej_nx, chg_pulse_nx, busy_nx;
    logic          free_vend, free_vend_nx;
    logic [TW-1:0] tmr, tmr_nx;

    logic [CW-1:0] sel_price;
    logic          sel_ok;
    logic [CW:0]   coin_sum;
    logic          coin_ok;

    // Requests that are actually acted on; an ignored request (CANCEL with
    // no credit, out-of-range SEL) does not block lower-priority inputs.
    logic          cancel_win, pass_win, sel_win, coin_take;

    always_comb begin
        sel_price = '0;
        for (int i = 0; i < N_PROD; i++)
            if (SEL == SW'(i)) sel_price = PRICES[i*CW +: CW];
    end

    assign sel_ok   = int'(SEL) < N_PROD;
    // Sum carries one extra bit so an overflowing coin is still rejected.
    assign coin_sum = {1'b0, CREDIT} + {1'b0, COIN_VAL};
    assign coin_ok  = (COIN_VAL != '0) && ((COIN_VAL % CW'(CHG_UNIT)) == '0) &&
                      (coin_sum <= (CW+1)'(MAX_CREDIT));

    assign cancel_win = CANCEL && (state == S_HOLD);
    assign pass_win   = PASS && sel_ok;
    assign sel_win    = SEL_VLD && sel_ok;
    assign coin_take  = COIN_VLD && coin_ok && !cancel_win && !pass_win && !sel_win;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned
        // and no latch is inferred.
        state_nx     = state;
        credit_nx    = CREDIT;
        vend_id_nx   = VEND_ID;
        free_vend_nx = free_vend;
        tmr_nx       = tmr;
        vend_nx      = 1'b0;
        coin_rej_nx  = 1'b0;
        chg_pulse_nx = 1'b0;

        case (state)
            S_IDLE, S_HOLD: begin
                // Idle timer: any activity clears it; it only counts in HOLD.
                if (SEL_VLD || PASS || CANCEL || coin_take) begin
                    tmr_nx = '0;
                end else if (state == S_HOLD) begin
                    if (tmr == TW'(TIMEOUT - 1)) begin
                        tmr_nx   = '0;
                        state_nx = S_CHANGE;
                    end else begin
                        tmr_nx = tmr + TW'(1);
                    end
                end

                if (cancel_win) begin
                    state_nx = S_CHANGE;
                end else if (pass_win) begin
                    state_nx     = S_VEND;
                    vend_id_nx   = SEL;
                    free_vend_nx = 1'b1;
                end else if (sel_win) begin
                    // Insufficient credit still wins priority but changes nothing.
                    if (CREDIT >= sel_price) begin
                        state_nx     = S_VEND;
                        credit_nx    = CREDIT - sel_price;
                        vend_id_nx   = SEL;
                        free_vend_nx = 1'b0;
                    end
                end else if (coin_take) begin
                    credit_nx = coin_sum[CW-1:0];
                    state_nx  = S_HOLD;
                end

                coin_rej_nx = COIN_VLD && !coin_take;
            end

            S_VEND: begin
                vend_nx     = 1'b1;
                coin_rej_nx = COIN_VLD;
                if (CREDIT == '0)   state_nx = S_IDLE;
                else if (free_vend) state_nx = S_HOLD;
                else                state_nx = S_CHANGE;
            end

            S_CHANGE: begin
                coin_rej_nx = COIN_VLD;
                if (CREDIT > CW'(CHG_UNIT)) begin
                    credit_nx    = CREDIT - CW'(CHG_UNIT);
                    chg_pulse_nx = 1'b1;
                end else begin
                    // Final unit (or nothing left): leave the same cycle credit hits 0.
                    chg_pulse_nx = (CREDIT != '0);
                    credit_nx    = '0;
                    state_nx     = S_IDLE;
                end
            end

            default: state_nx = S_IDLE;
        endcase

        busy_nx = (state_nx == S_VEND) || (state_nx == S_CHANGE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            CREDIT    <= '0;
            VEND      <= 1'b0;
            VEND_ID   <= '0;
            COIN_REJ  <= 1'b0;
            CHG_PULSE <= 1'b0;
            BUSY      <= 1'b0;
            free_vend <= 1'b0;
            tmr       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples the pre-edge values.
            state     <= state_nx;
            CREDIT    <= credit_nx;
            VEND      <= vend_nx;
            VEND_ID   <= vend_id_nx;
            COIN_REJ  <= coin_rej_nx;
            CHG_PULSE <= chg_pulse_nx;
            BUSY      <= busy_nx;
            free_vend <= free_vend_nx;
            tmr       <= tmr_nx;
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vend_ctrl
//   Self-checking bench for vend_ctrl. A transaction-level model keeps the
//   credit as an integer and, whenever a vend or refund starts, precomputes
//   the whole sequence of busy-cycle outputs into a queue. A compare process
//   checks every DUT output against the model on each falling edge. Directed
//   scenarios with literal expectations pin the model, then random stimulus
//   runs against it.
// ----------------------------------------------------------------------------
module tb_vend_ctrl;

    localparam int CW         = 8;
    localparam int N_PROD     = 4;
    localparam int SW         = 2;
    localparam int MAX_CREDIT = 200;
    localparam int CHG_UNIT   = 5;
    localparam int TIMEOUT    = 1000;

    logic          CLK = 1'b0;
    logic          RST;
    logic          COIN_VLD, SEL_VLD, PASS, CANCEL;
    logic [CW-1:0] COIN_VAL;
    logic [SW-1:0] SEL;
    logic [CW-1:0] CREDIT;
    logic          VEND, COIN_REJ, CHG_PULSE, BUSY;
    logic [SW-1:0] VEND_ID;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    vend_ctrl dut (
        .CLK      (CLK),
        .RST      (RST),
        .COIN_VLD (COIN_VLD),
        .COIN_VAL (COIN_VAL),
        .SEL_VLD  (SEL_VLD),
        .SEL      (SEL),
        .PASS     (PASS),
        .CANCEL   (CANCEL),
        .CREDIT   (CREDIT),
        .VEND     (VEND),
        .VEND_ID  (VEND_ID),
        .COIN_REJ (COIN_REJ),
        .CHG_PULSE(CHG_PULSE),
        .BUSY     (BUSY)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int credit;
        bit vend;
        bit chg;
        bit busy;
    } frame_t;

    int     price_of[N_PROD] = '{25, 50, 50, 75};
    frame_t plan[$];
    int     m_credit = 0, m_idle = 0, m_vend_id = 0;
    int     e_credit = 0, e_vend_id = 0;
    bit     e_vend = 0, e_rej = 0, e_chg = 0, e_busy = 0;
    bit     model_on = 0;

    // Queue one change pulse per unit of credit c, counting down to zero.
    task automatic refund(input int c);
        int n;
        n = c / CHG_UNIT;
        for (int j = 1; j <= n; j++)
            plan.push_back('{c - j * CHG_UNIT, 1'b0, 1'b1, j < n});
    endtask

    always @(posedge CLK) begin : model
        frame_t f;
        int     s, price;
        bit     hold, coin_ok, took;
        if (RST) begin
            plan.delete();
            m_credit = 0; m_idle = 0; m_vend_id = 0;
            e_vend = 0; e_rej = 0; e_chg = 0; e_busy = 0;
            model_on = 1;
        end else if (model_on) begin
            e_rej = COIN_VLD; e_vend = 0; e_chg = 0; e_busy = 0;
            if (plan.size() > 0) begin
                f = plan.pop_front();
                m_credit = f.credit; e_vend = f.vend; e_chg = f.chg; e_busy = f.busy;
            end else begin
                s       = int'(SEL);
                price   = (s < N_PROD) ? price_of[s] : 0;
                hold    = (m_credit > 0);
                coin_ok = COIN_VLD && (COIN_VAL != 0) && (int'(COIN_VAL) % CHG_UNIT == 0) &&
                          (m_credit + int'(COIN_VAL) <= MAX_CREDIT);
                took    = 0;
                if (CANCEL && hold) begin
                    refund(m_credit);
                end else if (PASS && s < N_PROD) begin
                    m_vend_id = s;
                    plan.push_back('{m_credit, 1'b1, 1'b0, 1'b0});
                end else if (SEL_VLD && s < N_PROD) begin
                    if (m_credit >= price) begin
                        m_vend_id = s;
                        m_credit  = m_credit - price;
                        plan.push_back('{m_credit, 1'b1, 1'b0, m_credit > 0});
                        refund(m_credit);
                    end
                end else if (coin_ok) begin
                    m_credit = m_credit + int'(COIN_VAL);
                    took     = 1;
                end
                if (took) e_rej = 0;
                if (SEL_VLD || PASS || CANCEL || took) begin
                    m_idle = 0;
                end else if (hold) begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        m_idle = 0;
                        refund(m_credit);
                    end
                end
                e_busy = (plan.size() > 0);
            end
        end
        e_credit  = m_credit;
        e_vend_id = m_vend_id;
    end

    always @(negedge CLK) begin
        if (model_on) begin
            check("credit", CREDIT, e_credit);
            check("vend", VEND, e_vend);
            check("coin_rej", COIN_REJ, e_rej);
            check("chg_pulse", CHG_PULSE, e_chg);
            check("busy", BUSY, e_busy);
            if (e_vend) check("vend_id", VEND_ID, e_vend_id);
        end
    end

    // ---------------- stimulus helpers ----------------
    int cyc = 0, win_pulses = 0, win_first = 0, win_last = 0;

    // One clock with the given inputs; returns at the next falling edge.
    task automatic step(input bit cv, input int val, input bit sv, input int sel,
                        input bit ps, input bit cn);
        COIN_VLD = cv; COIN_VAL = CW'(val); SEL_VLD = sv; SEL = SW'(sel);
        PASS = ps; CANCEL = cn;
        @(negedge CLK);
        COIN_VLD = 0; SEL_VLD = 0; PASS = 0; CANCEL = 0;
        if (CHG_PULSE === 1'b1) begin
            if (win_pulses == 0) win_first = cyc;
            win_last = cyc;
            win_pulses++;
        end
        cyc++;
    endtask

    task automatic coin(input int v);
        step(1, v, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic win_clear();
        win_pulses = 0; win_first = 0; win_last = 0;
    endtask

    task automatic do_reset();
        RST = 1;
        idle(1);
        RST = 0;
    endtask

    int coin_tab[10] = '{5, 10, 25, 50, 100, 7, 0, 3, 195, 200};

    initial begin : stim
        bit found;
        RST = 1; COIN_VLD = 0; COIN_VAL = '0; SEL_VLD = 0; SEL = '0; PASS = 0; CANCEL = 0;
        @(negedge CLK);
        idle(1);
        check("rst_credit", CREDIT, 0);
        check("rst_vend", VEND, 0);
        check("rst_vend_id", VEND_ID, 0);
        check("rst_coin_rej", COIN_REJ, 0);
        check("rst_chg", CHG_PULSE, 0);
        check("rst_busy", BUSY, 0);
        RST = 0;

        // 25+25+25, buy product 3 (75): exact payment, no change
        coin(25); coin(25); coin(25);
        check("t1_credit75", CREDIT, 75);
        step(0, 0, 1, 3, 0, 0);
        check("t1_busy", BUSY, 1);
        check("t1_credit0", CREDIT, 0);
        win_clear();
        idle(1);
        check("t1_vend", VEND, 1);
        check("t1_vend_id", VEND_ID, 3);
        idle(5);
        check("t1_no_chg", win_pulses, 0);
        check("t1_idle_busy", BUSY, 0);

        // 50+50, buy product 0 (25): 75 cents change = 15 consecutive pulses
        do_reset();
        coin(50); coin(50);
        step(0, 0, 1, 0, 0, 0);
        check("t2_credit75", CREDIT, 75);
        win_clear();
        idle(1);
        check("t2_vend", VEND, 1);
        check("t2_vend_id", VEND_ID, 0);
        check("t2_no_chg_with_vend", CHG_PULSE, 0);
        idle(25);
        check("t2_pulses", win_pulses, 15);
        check("t2_consecutive", win_last - win_first + 1, 15);
        check("t2_credit0", CREDIT, 0);

        // credit ceiling and bad coins
        do_reset();
        coin(50); coin(50); coin(50); coin(25); coin(10); coin(5);
        check("t3_credit190", CREDIT, 190);
        coin(25);
        check("t3_rej_over", COIN_REJ, 1);
        check("t3_credit_kept", CREDIT, 190);
        coin(7);
        check("t3_rej_odd", COIN_REJ, 1);
        idle(1);
        check("t3_rej_one_cycle", COIN_REJ, 0);
        coin(10);
        check("t3_at_max", CREDIT, 200);
        check("t3_max_accepted", COIN_REJ, 0);

        // cancel beats coin; then idle timeout refund
        do_reset();
        coin(25); coin(5);
        step(1, 10, 0, 0, 0, 1);
        check("t4_cancel_rej", COIN_REJ, 1);
        check("t4_cancel_credit", CREDIT, 30);
        win_clear();
        idle(12);
        check("t4_cancel_pulses", win_pulses, 6);
        check("t4_cancel_credit0", CREDIT, 0);
        coin(25); coin(5);
        win_clear();
        idle(TIMEOUT - 1);
        check("t4_not_yet", BUSY, 0);
        idle(1);
        check("t4_timeout_busy", BUSY, 1);
        check("t4_quiet", win_pulses, 0);
        idle(10);
        check("t4_timeout_pulses", win_pulses, 6);
        check("t4_timeout_credit0", CREDIT, 0);

        // free vend keeps credit and returns to HOLD
        do_reset();
        coin(25); coin(10); coin(5);
        step(0, 0, 0, 2, 1, 0);
        check("t5_credit", CREDIT, 40);
        idle(1);
        check("t5_vend", VEND, 1);
        check("t5_vend_id", VEND_ID, 2);
        idle(1);
        check("t5_hold_busy", BUSY, 0);
        check("t5_hold_credit", CREDIT, 40);

        // reset on the 3rd pulse of a 10-unit refund
        do_reset();
        coin(50);
        step(0, 0, 0, 0, 0, 1);
        win_clear();
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            idle(1);
            if (win_pulses == 3) found = 1;
        end
        check("t6_third_pulse_seen", found, 1);
        RST = 1;
        idle(1);
        RST = 0;
        check("t6_credit", CREDIT, 0);
        check("t6_chg", CHG_PULSE, 0);
        check("t6_busy", BUSY, 0);
        check("t6_vend", VEND, 0);
        check("t6_rej", COIN_REJ, 0);
        win_clear();
        idle(15);
        check("t6_no_more_pulses", win_pulses, 0);

        // random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(399) == 0) RST = 1;
            step($urandom_range(2) == 0, coin_tab[$urandom_range(9)],
                 $urandom_range(7) == 0, $urandom_range(N_PROD - 1),
                 $urandom_range(29) == 0, $urandom_range(39) == 0);
            RST = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
